// File: rtl/fpu_req_arbiter.sv
// Round-robin front end that shares one FPU between NREQ requesters:
// grant, one-cycle start pulse, watchdog-guarded wait for ready, response.
module fpu_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*70-1:0]        req_vec,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [40:0]               rsp_vec,
    output logic                      rsp_timeout,
    output logic                      busy,
    output logic [69:0]               fpu_test_vec,
    input  logic [40:0]               fpu_result_vec
);

    localparam int unsigned IW    = $clog2(NREQ);
    localparam int unsigned VW    = 70;
    localparam int unsigned OW    = 69;
    localparam int unsigned RW    = 41;
    localparam int unsigned CW    = $clog2(TIMEOUT + 1);
    localparam int unsigned RDY_B = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   rr, rr_n;
    logic [IW-1:0]   idx, idx_n;
    logic [OW-1:0]   op, op_n;
    logic            start, start_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_inc;
    logic            rsp_valid_n;
    logic [IW-1:0]   rsp_id_n;
    logic [RW-1:0]   rsp_vec_n;
    logic            rsp_timeout_n;
    logic            busy_n;

    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   cand;
    logic            unused_req_bits;

    // First pending requester at or after rr, wrapping upward
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = IW'((int'(rr) + k) % int'(NREQ));
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Bit 69 of each request slice carries no meaning
    always_comb begin
        unused_req_bits = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            unused_req_bits = unused_req_bits ^ req_vec[VW*i + OW];
        end
    end

    always_comb begin
        state_n       = state;
        rr_n          = rr;
        idx_n         = idx;
        op_n          = op;
        start_n       = 1'b0;
        cnt_n         = cnt;
        rsp_valid_n   = 1'b0;
        rsp_id_n      = rsp_id;
        rsp_vec_n     = rsp_vec;
        rsp_timeout_n = rsp_timeout;
        req_ready     = '0;
        cnt_inc       = cnt + CW'(1);

        case (state)
            S_IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    idx_n   = gnt_idx;
                    op_n    = req_vec[VW*32'(gnt_idx) +: OW];
                    rr_n    = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
                    start_n = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_n   = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                cnt_n = cnt_inc;
                // cnt == 0 marks the blanking cycle: ready left over from the previous op
                if (cnt != '0 && fpu_result_vec[RDY_B]) begin
                    rsp_vec_n     = fpu_result_vec;
                    rsp_timeout_n = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_id_n      = idx;
                    state_n       = S_RESP;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    rsp_vec_n     = '0;
                    rsp_timeout_n = 1'b1;
                    rsp_valid_n   = 1'b1;
                    rsp_id_n      = idx;
                    state_n       = S_RESP;
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            rr          <= '0;
            idx         <= '0;
            op          <= '0;
            start       <= 1'b0;
            cnt         <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_vec     <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            rr          <= rr_n;
            idx         <= idx_n;
            op          <= op_n;
            start       <= start_n;
            cnt         <= cnt_n;
            rsp_valid   <= rsp_valid_n;
            rsp_id      <= rsp_id_n;
            rsp_vec     <= rsp_vec_n;
            rsp_timeout <= rsp_timeout_n;
            busy        <= busy_n;
        end
    end

    assign fpu_test_vec = {start, op};

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Scoreboard bench for fpu_req_arbiter with a behavioural FPU mock whose
// ready timing is selected per operation.
module tb_fpu_req_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*70-1:0]   req_vec;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    logic [40:0]          rsp_vec;
    logic                 rsp_timeout;
    logic                 busy;
    logic [69:0]          fpu_test_vec;
    logic [40:0]          fpu_result_vec;

    fpu_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_vec        (req_vec),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_vec        (rsp_vec),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy),
        .fpu_test_vec   (fpu_test_vec),
        .fpu_result_vec (fpu_result_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned id;
        logic [40:0] vec;
        logic        tout;
        int unsigned lat;
    } rsp_t;

    typedef enum int {M_NORMAL, M_STALE, M_NEVER} fmode_t;

    rsp_t        rsp_q[$];
    int unsigned gnt_q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned gnt_cnt  = 0;
    int unsigned rsp_cnt  = 0;
    int unsigned gnt_cyc  = 0;

    fmode_t      fmode  = M_NORMAL;
    int unsigned fdelay = 2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Mock FPU: multiply by 1.0 returns opb, every other op returns opa ^ opb
    function automatic logic [31:0] fpu_model(input logic [68:0] v);
        logic [31:0] a, b;
        logic [2:0]  o;
        a = v[31:0];
        b = v[63:32];
        o = v[66:64];
        if (o == 3'd2 && a == 32'h3F80_0000) return b;
        return a ^ b;
    endfunction

    // Ready is driven per cycle relative to the start pulse seen at cycle s_cyc
    initial begin : fpu_mock
        int unsigned s_cyc;
        logic        started;
        logic [68:0] lat;
        logic        rdy;
        logic [31:0] res;
        started = 1'b0;
        s_cyc   = 0;
        lat     = '0;
        fpu_result_vec = '0;
        forever begin
            @(posedge clk);
            #1;
            if (fpu_test_vec[69]) begin
                s_cyc   = cyc;
                started = 1'b1;
                lat     = fpu_test_vec[68:0];
            end
            rdy = 1'b0;
            res = '0;
            if (started) begin
                case (fmode)
                    M_NORMAL: if (cyc >= s_cyc + fdelay) begin
                        rdy = 1'b1;
                        res = fpu_model(lat);
                    end
                    M_STALE: if (cyc <= s_cyc + 1) begin
                        rdy = 1'b1;
                        res = 32'hDEAD_BEEF;
                    end else if (cyc >= s_cyc + 5) begin
                        rdy = 1'b1;
                        res = fpu_model(lat);
                    end
                    default: ;
                endcase
            end
            fpu_result_vec = {8'h00, rdy, res};
        end
    end

    // Monitor: grants and responses checked against the expectation queues
    always @(negedge clk) begin : monitor
        logic [NREQ-1:0] g;
        int unsigned     eg;
        rsp_t            er;
        g = req_valid & req_ready;
        if (busy && req_valid != '0) check("no_grant_while_busy", 64'(req_ready), 64'd0);
        if (g != '0) begin
            check("grant_onehot", 64'($onehot(g)), 64'd1);
            if (gnt_q.size() == 0) begin
                check("unexpected_grant", 64'(g), 64'd0);
            end else begin
                eg = gnt_q.pop_front();
                check("grant_id", 64'(g), 64'(1) << eg);
            end
            gnt_cyc = cyc;
            gnt_cnt++;
        end
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                er = rsp_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(er.id));
                check("rsp_vec", 64'(rsp_vec), 64'(er.vec));
                check("rsp_timeout", 64'(rsp_timeout), 64'(er.tout));
                check("rsp_latency", 64'(cyc - gnt_cyc), 64'(er.lat));
            end
            rsp_cnt++;
        end
    end

    task automatic check_reset_outputs();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_vec", 64'(rsp_vec), 64'd0);
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fpu_test_vec", 64'(fpu_test_vec), 64'd0);
    endtask

    // One operation from requester idx with the other mask bits as competitors
    task automatic run_op(input int unsigned idx, input logic [NREQ-1:0] mask,
                          input logic [31:0] opa, input logic [31:0] opb,
                          input logic [2:0] op, input logic [1:0] rmode,
                          input fmode_t m, input int unsigned d,
                          input logic [40:0] exp_vec, input logic exp_to,
                          input int unsigned exp_lat);
        int unsigned g0, r0;
        rsp_t e;
        req_vec[70*idx +: 70] = {1'b0, rmode, op, opb, opa};
        fmode  = m;
        fdelay = d;
        e.id = idx; e.vec = exp_vec; e.tout = exp_to; e.lat = exp_lat;
        gnt_q.push_back(idx);
        rsp_q.push_back(e);
        g0 = gnt_cnt;
        r0 = rsp_cnt;
        req_valid = mask;
        for (int i = 0; i < 50 && gnt_cnt == g0; i++) begin
            @(posedge clk); #2;
        end
        req_valid = '0;
        if (gnt_cnt == g0) check("grant_wait", 64'(gnt_cnt), 64'(g0 + 1));
        for (int i = 0; i < 50 && rsp_cnt == r0; i++) begin
            @(posedge clk); #2;
        end
        if (rsp_cnt == r0) check("rsp_wait", 64'(rsp_cnt), 64'(r0 + 1));
        gnt_q.delete();
        rsp_q.delete();
        @(posedge clk); #2;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "tb_fpu_req_arbiter watchdog");
    end

    logic [31:0] rr_opa [4] = '{32'h1111_1111, 32'h2222_2222, 32'h4444_4444, 32'h8888_8888};
    logic [31:0] rr_exp [4] = '{32'h1E1E_1E1E, 32'h2D2D_2D2D, 32'h4B4B_4B4B, 32'h8787_8787};

    initial begin : stimulus
        int unsigned g0, r0;
        rsp_t e;
        rst       = 1'b0;
        req_valid = '0;
        req_vec   = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        check_reset_outputs();

        // Round-robin from reset: all requesters held, min-latency FPU
        for (int i = 0; i < 4; i++) req_vec[70*i +: 70] = {1'b0, 2'd0, 3'd0, 32'h0F0F_0F0F, rr_opa[i]};
        fmode  = M_NORMAL;
        fdelay = 2;
        for (int k = 0; k < 8; k++) begin
            gnt_q.push_back(k % 4);
            e.id = k % 4; e.vec = {8'h00, 1'b1, rr_exp[k % 4]}; e.tout = 1'b0; e.lat = 4;
            rsp_q.push_back(e);
        end
        g0 = gnt_cnt;
        r0 = rsp_cnt;
        req_valid = '1;
        for (int i = 0; i < 200 && gnt_cnt < g0 + 8; i++) begin
            @(posedge clk); #2;
        end
        req_valid = '0;
        for (int i = 0; i < 50 && rsp_cnt < r0 + 8; i++) begin
            @(posedge clk); #2;
        end
        check("rr_grant_count", 64'(gnt_cnt - g0), 64'd8);
        check("rr_rsp_count", 64'(rsp_cnt - r0), 64'd8);
        gnt_q.delete();
        rsp_q.delete();
        @(posedge clk); #2;

        // Single request: 1.0 * 2.0, ready 5 cycles after start
        run_op(2, 4'b0100, 32'h3F80_0000, 32'h4000_0000, 3'd2, 2'd0, M_NORMAL, 5,
               {8'h00, 1'b1, 32'h4000_0000}, 1'b0, 7);

        // Stale ready through start and blanking must not be captured
        run_op(0, 4'b0001, 32'h0000_FFFF, 32'h00FF_00FF, 3'd1, 2'd1, M_STALE, 0,
               {8'h00, 1'b1, 32'h00FF_FF00}, 1'b0, 7);

        // Watchdog abort, then a normal operation
        run_op(1, 4'b0010, 32'h1234_0000, 32'h0000_4321, 3'd0, 2'd0, M_NEVER, 0,
               41'd0, 1'b1, 10);
        check("timeout_hold_vec", 64'(rsp_vec), 64'd0);
        check("timeout_hold_flag", 64'(rsp_timeout), 64'd1);
        run_op(2, 4'b0100, 32'hA5A5_0000, 32'h0000_5A5A, 3'd0, 2'd0, M_NORMAL, 3,
               {8'h00, 1'b1, 32'hA5A5_5A5A}, 1'b0, 5);

        // Ready first seen on the cycle the watchdog reaches TIMEOUT
        run_op(3, 4'b1000, 32'h1234_5678, 32'hFFFF_0000, 3'd0, 2'd2, M_NORMAL, 8,
               {8'h00, 1'b1, 32'hEDCB_5678}, 1'b0, 10);
        check("hold_rsp_id", 64'(rsp_id), 64'd3);

        // Reset during WAIT: operation dropped, pointer back to 0
        req_vec[70*1 +: 70] = {1'b0, 2'd0, 3'd0, 32'h0000_00FF, 32'h0000_FF00};
        fmode  = M_NORMAL;
        fdelay = 5;
        gnt_q.push_back(1);
        g0 = gnt_cnt;
        r0 = rsp_cnt;
        req_valid = 4'b0010;
        for (int i = 0; i < 50 && gnt_cnt == g0; i++) begin
            @(posedge clk); #2;
        end
        req_valid = '0;
        check("rstw_grant_seen", 64'(gnt_cnt - g0), 64'd1);
        @(posedge clk); #2;
        check("rstw_busy_in_wait", 64'(busy), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        repeat (12) @(posedge clk);
        #2;
        check("rstw_no_response", 64'(rsp_cnt - r0), 64'd0);
        check("rstw_busy_idle", 64'(busy), 64'd0);
        gnt_q.delete();
        rsp_q.delete();
        run_op(0, 4'b0111, 32'h0F00_0000, 32'h00F0_0000, 3'd0, 2'd0, M_NORMAL, 2,
               {8'h00, 1'b1, 32'h0FF0_0000}, 1'b0, 4);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_req_arbiter.md
# fpu_req_arbiter

Shares one `fpu` instance between `NREQ` independent requesters. Round-robin grant selects one operation, which is latched and issued as a one-cycle start pulse on the FPU's 70-bit test-vector bus. The block waits for `ready` with a watchdog, then returns the 41-bit result vector to the granted requester. It sits directly in front of the `fpu` toplevel instance, in the position the golden-circuit wrapper's stimulus source occupies.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 63: maximum number of WAIT cycles before abort (≥4).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_vec` in NREQ*70: operation of requester i in bits [70*i+68 : 70*i]. Layout is opa[31:0], opb[63:32], op[66:64], rmode[68:67]. Bit 70*i+69 is ignored.
- `req_ready` out NREQ: one-hot grant; the transfer occurs when `req_valid[i] & req_ready[i]`.
- `rsp_valid` out 1: one-cycle response strobe; no backpressure.
- `rsp_id` out clog2(NREQ): index of the requester the response belongs to.
- `rsp_vec` out 41: captured FPU result vector. Layout is output[31:0], ready[32], ine, overflow, underflow, div0zero, inf, zero, qnan, snan[40].
- `rsp_timeout` out 1: with `rsp_valid`, the operation aborted; `rsp_vec` = 0.
- `busy` out 1: state ≠ IDLE.
- `fpu_test_vec` out 70: drives the FPU. Bits [68:0] are the latched operation; bit 69 is start.
- `fpu_result_vec` in 41: FPU result vector; bit 32 is ready.

## Operation
- FSM states are IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**: if any `req_valid` is set, grant the first set bit at or after pointer `rr`, searching upward and wrapping. `req_ready` asserts combinationally for that bit only. Latch `req_vec` slice [68:0] and the index, set `rr` = index+1 mod NREQ, and go to ISSUE. With no request, stay in IDLE; `req_ready` = 0.
- `req_ready` is 0 in every state other than IDLE.
- **ISSUE**: `fpu_test_vec[69]` = 1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- **WAIT**:
  - The first WAIT cycle is a blanking cycle: `fpu_result_vec[32]` is ignored, which discards stale ready from the previous operation.
  - From the second WAIT cycle on, ready = 1 captures `fpu_result_vec` into `rsp_vec` and goes to RESP.
  - The counter increments every WAIT cycle. If the counter reaches `TIMEOUT` without a capture, go to RESP with `rsp_timeout` = 1 and `rsp_vec` = 0.
  - If ready arrives on the cycle the counter hits `TIMEOUT`, the capture wins.
- **RESP**: `rsp_valid` = 1 and `rsp_id` = latched index for one cycle, then go to IDLE.
- `fpu_test_vec[68:0]` holds the latched operation from ISSUE until the next grant. The FPU inputs stay stable throughout WAIT.
- Watchdog counter width is clog2(TIMEOUT+1) and it never wraps.
- A request withdrawn before grant is legal and produces no response.

## Timing
- Grant at cycle T, start at T+1, blanking at T+2. Ready is sampled from T+3.
- Ready seen at cycle W gives `rsp_valid` at W+1. The earliest next grant is at W+2.
- Minimum grant-to-response latency is 4 cycles. Timeout response comes at T+2+TIMEOUT.
- Reset values: state IDLE, `rr` = 0, `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_vec` = 0, `rsp_timeout` = 0, `busy` = 0, `fpu_test_vec` = 0.
- Reset asserted mid-operation (any state) returns immediately to IDLE. No response is emitted, the pending request is lost, and a later FPU ready is ignored.
- `rsp_vec`, `rsp_id` and `rsp_timeout` hold their values after RESP until the next capture or timeout.

## Test plan
- **Single request**: requester 2 sends opa=0x3F800000, opb=0x40000000, op=2 (mul), rmode=0. FPU model gives ready 5 cycles after start with output 0x40000000. Expect `rsp_valid` once, `rsp_id`=2, `rsp_vec[31:0]`=0x40000000, `rsp_timeout`=0.
- **Round-robin**: all 4 `req_valid` held high for 8 operations starting from reset. Expect grant order 0,1,2,3,0,1,2,3, one response per grant, and no grant while `busy`.
- **Stale ready**: the FPU model keeps ready=1 through the start cycle and the blanking cycle, then drops it for 3 cycles and raises it again. Expect capture only on the re-raised ready, not on the blanking cycle.
- **Timeout**: `TIMEOUT`=8 with ready held 0. Expect `rsp_valid` with `rsp_timeout`=1 and `rsp_vec`=0 exactly at T+10. A following request completes normally.
- **Ready at timeout**: ready first appears on the cycle the counter hits `TIMEOUT`. Expect a normal capture with `rsp_timeout`=0.
- **Reset mid-WAIT**: assert `rst`=0 for 1 cycle during WAIT. Expect all outputs at reset values, no `rsp_valid`, and the next grant going to requester 0.
